motion_cmd_sched: RTL

Frame-rate motion scheduler for the player sprite. It queues W/A/S/D direction commands from the PS/2 keyboard decoder and arbitrates sprite ownership between the keyboard and a demo/autopilot requester. Once per frame it produces the signed X/Y motion step consumed by the sprite position datapath. Wall bounce is handled here, so the position datapath only adds motion to position.

---
 rtl/motion_cmd_sched_pkg.sv | 51 +++++
 rtl/motion_cmd_sched_if.sv | 38 +++
 rtl/motion_cmd_sched_cmd_fifo.sv | 74 +++++++
 rtl/motion_cmd_sched.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/motion_cmd_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : motion_pkg
//  Description : Shared types, keycodes and direction-to-step mapping for the
//                sprite motion scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package motion_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        LEFT  = 2'd1,
        DOWN  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        DEMO = 2'd2
    } sched_state_t;

    // PS/2 set-2 make codes for the W/A/S/D keys
    localparam logic [7:0] KC_W = 8'h1D;
    localparam logic [7:0] KC_A = 8'h1C;
    localparam logic [7:0] KC_S = 8'h1B;
    localparam logic [7:0] KC_D = 8'h23;

    typedef struct packed {
        logic [9:0] dx;
        logic [9:0] dy;
    } step_t;

    // Signed (dx, dy) step for a direction; screen Y grows downward
    function automatic step_t dir_step(input dir_t d, input logic [9:0] step);
        step_t      s;
        logic [9:0] neg;
        neg  = ~step + 10'd1;
        s.dx = '0;
        s.dy = '0;
        case (d)
            UP:      s.dy = neg;
            DOWN:    s.dy = step;
            LEFT:    s.dx = neg;
            default: s.dx = step;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/motion_cmd_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : motion_cmd_sched_if
//  Description : Keyboard, demo requester, wall-flag and motion output bundle
//                of the motion scheduler. master = environment, slave = block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface motion_cmd_sched_if;
    logic       frame_tick;
    logic       key_valid;
    logic       press;
    logic [7:0] keycode;
    logic       demo_valid;
    logic [1:0] demo_dir;
    logic       demo_ready;
    logic       at_x_min;
    logic       at_x_max;
    logic       at_y_min;
    logic       at_y_max;
    logic [9:0] motion_x;
    logic [9:0] motion_y;
    logic [1:0] dir;
    logic       owner;
    logic       cmd_overflow;

    modport master (
        output frame_tick, key_valid, press, keycode, demo_valid, demo_dir,
               at_x_min, at_x_max, at_y_min, at_y_max,
        input  demo_ready, motion_x, motion_y, dir, owner, cmd_overflow
    );

    modport slave (
        input  frame_tick, key_valid, press, keycode, demo_valid, demo_dir,
               at_x_min, at_x_max, at_y_min, at_y_max,
        output demo_ready, motion_x, motion_y, dir, owner, cmd_overflow
    );
endinterface
`default_nettype wire

// File: rtl/motion_cmd_sched_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_fifo
//  Description : Synchronous FIFO of direction commands. A push on a full
//                FIFO is accepted when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo
    import motion_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic Clk,
    input  wire logic Reset,
    input  wire logic push,
    input  wire dir_t push_dir,
    input  wire logic pop,
    output dir_t      head,
    output logic      full,
    output logic      empty
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    dir_t          mem_q [DEPTH];
    dir_t          mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign head  = mem_q[rd_ptr_q];

    // Pointer, occupancy and storage update
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dir;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // FIFO state registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= UP;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/motion_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : motion_cmd_sched
//  Description : Per-frame sprite motion scheduler: queues W/A/S/D commands,
//                hands the sprite to a demo requester after IDLE_FRAMES empty
//                frames, and applies wall bounce to the motion step.
//                Optional: MOTION_NO_REVERSE_EN discards commands that would
//                reverse a moving sprite.
//  Revision    : 1.0 - initial release
// ============================================================================
module motion_cmd_sched
    import motion_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [9:0] STEP        = 10'd1,
    parameter int         IDLE_FRAMES = 600
) (
    input wire logic          Clk,
    input wire logic          Reset,
    motion_cmd_sched_if.slave bus
);
    localparam int               CNT_W     = $clog2(IDLE_FRAMES + 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_FRAMES - 1);
    localparam logic [9:0]       NEG_STEP  = ~STEP + 10'd1;

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [9:0]       motion_x_q, motion_x_d, motion_y_q, motion_y_d;
    dir_t             dir_q, dir_d, pend_dir_q, pend_dir_d;
    logic             pend_q, pend_d;
    logic             owner_q, owner_d;
    logic             demo_ready_q, demo_ready_d;
    logic             ovf_q, ovf_d;

    logic  key_hit, push_ok, fifo_pop, fifo_full, fifo_empty;
    dir_t  key_dir, fifo_head, cmd_dir;
    logic  cmd_valid, cmd_blocked;
    step_t cmd_step;

    // Decode make codes of the four movement keys
    always_comb begin
        key_hit = 1'b0;
        key_dir = UP;
        if (bus.key_valid && bus.press) begin
            case (bus.keycode)
                KC_W:    begin key_hit = 1'b1; key_dir = UP;    end
                KC_A:    begin key_hit = 1'b1; key_dir = LEFT;  end
                KC_S:    begin key_hit = 1'b1; key_dir = DOWN;  end
                KC_D:    begin key_hit = 1'b1; key_dir = RIGHT; end
                default: ;
            endcase
        end
    end

    // Pop on a keyboard-side frame; a same-cycle pop frees room for a push
    assign fifo_pop = bus.frame_tick && !fifo_empty && (state_q != DEMO);
    assign push_ok  = key_hit && (!fifo_full || fifo_pop);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .Clk      (Clk),
        .Reset    (Reset),
        .push     (push_ok),
        .push_dir (key_dir),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Ownership FSM, command selection, motion update and wall bounce
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        motion_x_d  = motion_x_q;
        motion_y_d  = motion_y_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        pend_dir_d  = pend_dir_q;
        ovf_d       = ovf_q | (key_hit & ~push_ok);
        cmd_valid   = 1'b0;
        cmd_dir     = dir_q;
        cmd_blocked = 1'b0;
        cmd_step    = '0;

        // demo_ready is only high with nothing pending, so no clash with a tick
        if (bus.demo_valid && demo_ready_q) begin
            pend_d     = 1'b1;
            pend_dir_d = dir_t'(bus.demo_dir);
        end

        case (state_q)
            DEMO: begin
                if (push_ok) begin
                    state_d = KEY;
                    pend_d  = 1'b0;
                end else if (bus.frame_tick && pend_q) begin
                    cmd_valid = 1'b1;
                    cmd_dir   = pend_dir_q;
                    pend_d    = 1'b0;
                end
            end
            default: begin
                if (bus.frame_tick) begin
                    if (fifo_pop) begin
                        cmd_valid  = 1'b1;
                        cmd_dir    = fifo_head;
                        state_d    = KEY;
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        // A key landing on the takeover frame keeps the keyboard in charge
                        state_d    = push_ok ? KEY : DEMO;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase

`ifdef MOTION_NO_REVERSE_EN
        cmd_blocked = ((cmd_dir ^ dir_q) == 2'b10) && ((motion_x_q | motion_y_q) != 10'd0);
`endif

        if (cmd_valid && !cmd_blocked) begin
            dir_d      = cmd_dir;
            cmd_step   = dir_step(cmd_dir, STEP);
            motion_x_d = cmd_step.dx;
            motion_y_d = cmd_step.dy;
        end

        // Bounce overrides the command; only a moving component reacts
        if (bus.frame_tick) begin
            if (motion_x_d != 10'd0) begin
                if (bus.at_x_max)      motion_x_d = NEG_STEP;
                else if (bus.at_x_min) motion_x_d = STEP;
            end
            if (motion_y_d != 10'd0) begin
                if (bus.at_y_max)      motion_y_d = NEG_STEP;
                else if (bus.at_y_min) motion_y_d = STEP;
            end
        end

        owner_d      = (state_d == DEMO);
        demo_ready_d = (state_d == DEMO) && !pend_d;
    end

    // Scheduler state and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            idle_cnt_q   <= '0;
            motion_x_q   <= '0;
            motion_y_q   <= '0;
            dir_q        <= UP;
            pend_q       <= 1'b0;
            pend_dir_q   <= UP;
            owner_q      <= 1'b0;
            demo_ready_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            motion_x_q   <= motion_x_d;
            motion_y_q   <= motion_y_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            pend_dir_q   <= pend_dir_d;
            owner_q      <= owner_d;
            demo_ready_q <= demo_ready_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.motion_x     = motion_x_q;
    assign bus.motion_y     = motion_y_q;
    assign bus.dir          = dir_q;
    assign bus.owner        = owner_q;
    assign bus.demo_ready   = demo_ready_q;
    assign bus.cmd_overflow = ovf_q;
endmodule
`default_nettype wire
